run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_seq_pkg.sv | 17 +
 rtl/rise_detect.sv | 22 ++
 rtl/run_sequencer.sv | 146 ++++++++++++++
 tb/tb_run_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default sizing for the run sequencer.
package run_seq_pkg;

    localparam int unsigned HOLD_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 32;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_STEP,
        ST_WAIT_IN,
        ST_LOAD_IN,
        ST_SHOW_OUT,
        ST_EMIT,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/rise_detect.sv
// 0->1 detector on a synchronous level; the previous sample resets high so a
// level held through reset never reports an edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise_c
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise_c = i_level & ~r_prev;

endmodule

// File: rtl/run_sequencer.sv
// Execution sequencer: pauses the datapath for switch input, printed-value
// display, single stepping and halt, and counts retired instructions.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_input,
    input  logic             is_print,
    input  logic             is_halt,
    input  logic [31:0]      alu_result,
    input  logic             confirm,
    input  logic             step_mode,
    input  logic             step_btn,
    output logic             pause,
    output logic             read,
    output logic             print_strobe,
    output logic [31:0]      display_data,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_print_strobe;
    logic [31:0]        r_display;
    logic               r_halted;
    logic [CNT_W-1:0]   r_count;
    logic               w_pause;
    logic               w_read;
    logic               w_load_print;
    logic               w_confirm_rise;
    logic               w_step_rise;

    rise_detect u_confirm_rise (
        .clk      (clk),
        .reset    (reset),
        .i_level  (confirm),
        .o_rise_c (w_confirm_rise)
    );

    rise_detect u_step_rise (
        .clk      (clk),
        .reset    (reset),
        .i_level  (step_btn),
        .o_rise_c (w_step_rise)
    );

    // Next state plus the combinational pause/read controls.
    always_comb begin
        w_next       = r_state;
        w_pause      = 1'b1;
        w_read       = 1'b0;
        w_load_print = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (is_halt) begin
                    w_next = ST_HALT;
                end else if (is_input) begin
                    w_next = ST_WAIT_IN;
                end else if (is_print) begin
                    w_next       = ST_SHOW_OUT;
                    w_load_print = 1'b1;
                end else begin
                    w_pause = 1'b0;
                    w_next  = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_STEP: begin
                if (w_step_rise || !step_mode) begin
                    w_next = ST_RUN;
                end
            end
            ST_WAIT_IN: begin
                if (w_confirm_rise) begin
                    w_next = ST_LOAD_IN;
                end
            end
            ST_LOAD_IN: begin
                w_pause = 1'b0;
                w_read  = 1'b1;
                w_next  = step_mode ? ST_STEP : ST_RUN;
            end
            ST_SHOW_OUT: begin
                if ((r_hold == HOLD_MAX) && w_confirm_rise) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_pause = 1'b0;
                w_next  = step_mode ? ST_STEP : ST_RUN;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
        // A reset cycle never retires and never strobes read.
        if (reset) begin
            w_pause      = 1'b1;
            w_read       = 1'b0;
            w_load_print = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_hold         <= '0;
            r_print_strobe <= 1'b0;
            r_display      <= 32'd0;
            r_halted       <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state        <= w_next;
            r_print_strobe <= w_load_print;
            r_halted       <= (w_next == ST_HALT);
            if (w_load_print) begin
                r_display <= alu_result;
                r_hold    <= '0;
            end else if ((r_state == ST_SHOW_OUT) && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
            if (!w_pause) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign pause        = w_pause;
    assign read         = w_read;
    assign print_strobe = r_print_strobe;
    assign display_data = r_display;
    assign halted       = r_halted;
    assign instr_count  = r_count;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed scenarios plus a per-cycle behavioural model.
module tb_run_sequencer;

    localparam int unsigned HOLD = 4;
    localparam int unsigned CW   = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          is_input   = 1'b0;
    logic          is_print   = 1'b0;
    logic          is_halt    = 1'b0;
    logic [31:0]   alu_result = 32'd0;
    logic          confirm    = 1'b0;
    logic          step_mode  = 1'b0;
    logic          step_btn   = 1'b0;
    logic          pause;
    logic          read;
    logic          print_strobe;
    logic [31:0]   display_data;
    logic          halted;
    logic [CW-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    int reads_seen   = 0;
    int strobes_seen = 0;
    int retires_seen = 0;

    run_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .is_input     (is_input),
        .is_print     (is_print),
        .is_halt      (is_halt),
        .alu_result   (alu_result),
        .confirm      (confirm),
        .step_mode    (step_mode),
        .step_btn     (step_btn),
        .pause        (pause),
        .read         (read),
        .print_strobe (print_strobe),
        .display_data (display_data),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("reset_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
    endtask

    // Behavioural model: what the machine is waiting on, as independent flags.
    bit          m_halted   = 1'b0;
    bit          m_wait_in  = 1'b0;
    bit          m_loading  = 1'b0;
    int          m_show_age = -1;
    bit          m_emitting = 1'b0;
    bit          m_stepping = 1'b0;
    bit          m_strobe   = 1'b0;
    logic [31:0] m_disp     = 32'd0;
    logic [31:0] m_count    = 32'd0;
    bit          m_prev_conf = 1'b1;
    bit          m_prev_step = 1'b1;
    bit          e_pause;
    bit          e_read;
    bit          conf_edge;
    bit          step_edge;

    always @(negedge clk) begin
        if (mon_en) begin
            e_read = 1'b0;
            if (reset)                 e_pause = 1'b1;
            else if (m_halted)         e_pause = 1'b1;
            else if (m_wait_in)        e_pause = 1'b1;
            else if (m_loading)        begin e_pause = 1'b0; e_read = 1'b1; end
            else if (m_show_age >= 0)  e_pause = 1'b1;
            else if (m_emitting)       e_pause = 1'b0;
            else if (m_stepping)       e_pause = 1'b1;
            else                       e_pause = is_halt | is_input | is_print;

            chk("mon_pause",  32'(pause),        32'(e_pause));
            chk("mon_read",   32'(read),         32'(e_read));
            chk("mon_strobe", 32'(print_strobe), 32'(m_strobe));
            chk("mon_disp",   display_data,      m_disp);
            chk("mon_halted", 32'(halted),       32'(m_halted));
            chk("mon_count",  32'(instr_count),  m_count);

            if (read === 1'b1)         reads_seen++;
            if (print_strobe === 1'b1) strobes_seen++;
            if (pause === 1'b0)        retires_seen++;

            conf_edge   = confirm & ~m_prev_conf;
            step_edge   = step_btn & ~m_prev_step;
            m_prev_conf = reset ? 1'b1 : confirm;
            m_prev_step = reset ? 1'b1 : step_btn;
            m_strobe    = 1'b0;

            if (reset) begin
                m_halted = 0; m_wait_in = 0; m_loading = 0; m_show_age = -1;
                m_emitting = 0; m_stepping = 0; m_disp = 32'd0; m_count = 32'd0;
            end else begin
                if (!e_pause) m_count = m_count + 32'd1;
                if (m_halted) begin
                end else if (m_wait_in) begin
                    if (conf_edge) begin m_wait_in = 0; m_loading = 1; end
                end else if (m_loading) begin
                    m_loading = 0; m_stepping = step_mode;
                end else if (m_show_age >= 0) begin
                    if (m_show_age >= HOLD && conf_edge) begin
                        m_show_age = -1; m_emitting = 1;
                    end else if (m_show_age < HOLD) begin
                        m_show_age++;
                    end
                end else if (m_emitting) begin
                    m_emitting = 0; m_stepping = step_mode;
                end else if (m_stepping) begin
                    if (step_edge || !step_mode) m_stepping = 0;
                end else if (is_halt) begin
                    m_halted = 1;
                end else if (is_input) begin
                    m_wait_in = 1;
                end else if (is_print) begin
                    m_show_age = 0; m_strobe = 1; m_disp = alu_result;
                end else begin
                    m_stepping = step_mode;
                end
            end
        end
    end

    initial begin
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_count",  32'(instr_count),  32'd0);
        chk("rst_disp",   display_data,      32'd0);
        chk("rst_halted", 32'(halted),       32'd0);
        chk("rst_strobe", 32'(print_strobe), 32'd0);
        chk("rst_pause",  32'(pause),        32'd1);
        reset = 1'b0;
        #1;
        chk("run_pause", 32'(pause), 32'd0);

        // Plain run of five ordinary instructions.
        repeat (5) tick();
        chk("plain_count", 32'(instr_count), 32'd5);
        do_reset();

        // Switch input with confirm three cycles later.
        reads_seen = 0;
        is_input = 1'b1;
        repeat (3) tick();
        chk("in_wait_pause", 32'(pause), 32'd1);
        confirm = 1'b1;
        tick();
        confirm = 1'b0; is_input = 1'b0;
        #1;
        chk("in_load_read",  32'(read),  32'd1);
        chk("in_load_pause", 32'(pause), 32'd0);
        tick();
        chk("in_after_read", 32'(read), 32'd0);
        chk("in_count", 32'(instr_count), 32'd1);
        do_reset();
        chk("in_reads", 32'(reads_seen), 32'd1);

        // Print with an early (ignored) confirm and a later accepted one.
        strobes_seen = 0;
        is_print = 1'b1; alu_result = 32'hDEADBEEF;
        tick();
        chk("pr_strobe", 32'(print_strobe), 32'd1);
        chk("pr_disp", display_data, 32'hDEADBEEF);
        alu_result = 32'h0;
        tick();
        chk("pr_strobe_once", 32'(print_strobe), 32'd0);
        tick();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        #1;
        chk("pr_early_ignored", 32'(pause), 32'd1);
        repeat (3) tick();
        confirm = 1'b1;
        tick();
        confirm = 1'b0; is_print = 1'b0;
        #1;
        chk("pr_emit_pause", 32'(pause), 32'd0);
        chk("pr_emit_read",  32'(read),  32'd0);
        chk("pr_disp_hold",  display_data, 32'hDEADBEEF);
        tick();
        chk("pr_strobes", 32'(strobes_seen), 32'd1);
        do_reset();

        // Single step: three button pulses, then a held button.
        step_mode = 1'b1;
        tick();
        retires_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step_btn = 1'b1;
            tick();
            step_btn = 1'b0;
            tick();
            tick();
        end
        tick();
        chk("step_pulses", 32'(retires_seen), 32'd3);
        retires_seen = 0;
        step_btn = 1'b1;
        repeat (6) tick();
        chk("step_held", 32'(retires_seen), 32'd1);
        step_btn = 1'b0;
        step_mode = 1'b0;
        repeat (2) tick();
        do_reset();

        // Halt is permanent until reset.
        is_halt = 1'b1;
        tick();
        is_halt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            confirm  = ~confirm;
            step_btn = ~step_btn;
            tick();
        end
        chk("halt_flag",  32'(halted), 32'd1);
        chk("halt_pause", 32'(pause),  32'd1);
        confirm = 1'b0; step_btn = 1'b0;
        do_reset();
        chk("halt_cleared", 32'(halted), 32'd0);

        // Reset in WAIT_IN with confirm held; held confirm must not load.
        reads_seen = 0;
        is_input = 1'b1;
        repeat (2) tick();
        reset = 1'b1; confirm = 1'b1;
        tick();
        reset = 1'b0;
        chk("wr_count", 32'(instr_count), 32'd0);
        repeat (4) tick();
        chk("wr_held_pause", 32'(pause), 32'd1);
        chk("wr_no_read", 32'(reads_seen), 32'd0);
        confirm = 1'b0;
        tick();
        confirm = 1'b1;
        tick();
        confirm = 1'b0; is_input = 1'b0;
        #1;
        chk("wr_load_read", 32'(read), 32'd1);
        repeat (3) tick();
        chk("wr_reads", 32'(reads_seen), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
